// File: rtl/pwm_out_pkg.sv
// pwm_out_pkg -- shared constants for the PWM audio output stage.
//
// Holds the default sample/PWM widths and the constants derived from them:
//   RES_W    residual bits that fall below PWM resolution
//   MIDSCALE duty value loaded at reset (50% high)
//   CNT_MAX  last count of a PWM period
// Modules compute their own parameter-dependent versions of these so a
// non-default instance stays consistent; the values here describe the
// default build.

package pwm_out_pkg;

    localparam int SAMPLE_W_DEFAULT = 12;
    localparam int PWM_W_DEFAULT    = 8;

    localparam int RES_W    = SAMPLE_W_DEFAULT - PWM_W_DEFAULT;
    localparam int MIDSCALE = 2 ** (PWM_W_DEFAULT - 1);
    localparam int CNT_MAX  = (2 ** PWM_W_DEFAULT) - 1;

endpackage

// File: rtl/pwm_noise_shaper.sv
// pwm_noise_shaper -- quantises a held mixer sample down to a PWM duty value.
//
// Configuration macro: PWM_NOISE_SHAPE_EN
//   defined   : first-order error feedback. The residual bits below PWM
//               resolution are accumulated in an error register and carried
//               into the duty of a later period (duty saturates at all-ones).
//   undefined : plain truncation to the top PWM_W bits; no state is kept.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset (clears the error register)
//   i_load  in   strobe at the period wrap that consumes i_hold
//   i_hold  in   held sample, SAMPLE_W bits, unsigned
//   o_duty  out  quantised duty for i_hold (combinational)

module pwm_noise_shaper
    import pwm_out_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int PWM_W    = PWM_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [SAMPLE_W-1:0] i_hold,
    output logic [PWM_W-1:0]    o_duty
);

    localparam int R = SAMPLE_W - PWM_W;

`ifdef PWM_NOISE_SHAPE_EN

    logic [R-1:0]   r_err;
    logic [R:0]     w_acc;
    logic [PWM_W:0] w_sum;

    // Residual plus carried error; the extra bit is the carry into the duty.
    assign w_acc = {1'b0, i_hold[R-1:0]} + {1'b0, r_err};
    assign w_sum = {1'b0, i_hold[SAMPLE_W-1 -: PWM_W]} + {{PWM_W{1'b0}}, w_acc[R]};

    // A carry out of the top code would wrap to zero duty; clamp instead.
    assign o_duty = w_sum[PWM_W] ? {PWM_W{1'b1}} : w_sum[PWM_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (i_load) begin
            r_err <= w_acc[R-1:0];
        end
    end

`else

    assign o_duty = i_hold[SAMPLE_W-1 -: PWM_W];

    // Truncation needs no clock, reset, strobe or residual bits.
    logic w_unused;
    assign w_unused = ^{clk, rst_n, i_load, i_hold[R-1:0]};

`endif

endmodule

// File: rtl/pwm_audio_out.sv
// pwm_audio_out -- double-buffered PWM audio DAC driving uo_out[0].
//
// Samples arrive from the voice mixer over valid/ready into a holding
// register. At the end of every PWM period (2^PWM_W clocks) a held sample is
// quantised into the duty register; with no fresh sample the duty repeats
// and underrun pulses. A sample accepted in period N shapes period N+1.
//
// Configuration macro: PWM_NOISE_SHAPE_EN (see pwm_noise_shaper).
//
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   ena           in   design enable; low freezes modulation, forces pwm_out 0
//   sample_in     in   SAMPLE_W-bit unsigned sample, midscale 2^(SAMPLE_W-1)
//   sample_valid  in   sample_in valid, held until accepted
//   sample_ready  out  holding register empty (combinational)
//   pwm_out       out  registered PWM bit
//   period_start  out  one-cycle pulse in the first cycle of each period
//   underrun      out  one-cycle pulse when a period starts without a sample

module pwm_audio_out
    import pwm_out_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int PWM_W    = PWM_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                pwm_out,
    output logic                period_start,
    output logic                underrun
);

    localparam logic [PWM_W-1:0] L_CNT_MAX  = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] L_MIDSCALE = {1'b1, {(PWM_W-1){1'b0}}};

    logic [PWM_W-1:0]    r_cnt;
    logic [PWM_W-1:0]    r_duty;
    logic [SAMPLE_W-1:0] r_hold;
    logic                r_hold_full;
    logic                r_pwm;
    logic                r_period_start;
    logic                r_underrun;

    logic                w_wrap;
    logic                w_consume;
    logic                w_accept;
    logic [PWM_W-1:0]    w_cnt_next;
    logic [PWM_W-1:0]    w_duty_q;
    logic [PWM_W-1:0]    w_duty_next;

    assign w_wrap    = ena && (r_cnt == L_CNT_MAX);
    assign w_consume = w_wrap && r_hold_full;
    // Only an empty holding register accepts, so accept and consume are
    // mutually exclusive; a sample accepted on an empty wrap waits a period.
    assign w_accept  = sample_valid && !r_hold_full;

    assign w_cnt_next  = ena ? r_cnt + 1'b1 : r_cnt;
    assign w_duty_next = w_consume ? w_duty_q : r_duty;

    pwm_noise_shaper #(
        .SAMPLE_W (SAMPLE_W),
        .PWM_W    (PWM_W)
    ) u_shaper (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_consume),
        .i_hold (r_hold),
        .o_duty (w_duty_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_duty         <= L_MIDSCALE;
            r_hold         <= '0;
            r_hold_full    <= 1'b0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_next;
            r_duty         <= w_duty_next;
            // Compare against next-state values so the registered bit lines
            // up with the count it belongs to.
            r_pwm          <= ena && (w_cnt_next < w_duty_next);
            r_period_start <= w_wrap;
            r_underrun     <= w_wrap && !r_hold_full;
            if (w_accept) begin
                r_hold <= sample_in;
            end
            if (w_consume) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
            end
        end
    end

    assign sample_ready = !r_hold_full;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign underrun     = r_underrun;

endmodule
